perf_halt_mon: RTL and testbench

- Observation stage directly downstream of the mipse core's data-memory port; it taps the same bus that feeds dmem.
- Counts execution cycles and stall cycles.
- Detects the program-termination store to HALT_ADDR and latches the value written there as the program result.
- Keeps a small FIFO trace of all other stores, which a bench or host drains through a ready/valid port.

---
 rtl/perf_halt_mon.sv | 146 ++++++++++++++
 tb/tb_perf_halt_mon.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/perf_halt_mon.sv
// sync_fifo: show-ahead FIFO with registered storage; head valid the cycle after a push.
// Latency: push to visible head is 1 cycle; pop takes effect on the accepting edge.
// Backpressure: push_rdy drops when full unless the head is popped in the same cycle.
module sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  input  logic         pop_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic [W-1:0] last_dat;
  logic         empty, full, do_push, do_pop;

  always_comb begin
    empty    = (wptr == rptr);
    full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    do_pop   = !empty && pop_rdy;
    push_rdy = !full || pop_rdy;
    do_push  = push_vld && push_rdy;
    pop_vld  = !empty;
    // Once drained, keep showing the last head rather than a stale slot.
    pop_dat  = empty ? last_dat : mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      last_dat <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop) begin
        rptr     <= rptr + PTR_ONE;
        last_dat <= mem[rptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_dat;
  end
endmodule

// perf_halt_mon: counts run/stall cycles, captures the halt-store result, traces other stores.
// Latency: halted/result/counters update 1 cycle after the sampled edge; trace entries 1 cycle.
// Backpressure: trace_ready pops the head; stores arriving while the FIFO is full are dropped.
module perf_halt_mon #(
  parameter int                DATA_W      = 32,
  parameter int                CNT_W       = 32,
  parameter logic [DATA_W-1:0] HALT_ADDR   = 32'h0000_7fff,
  parameter int                TRACE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              stall,
  output logic              halted,
  output logic [DATA_W-1:0] result,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              trace_valid,
  output logic [DATA_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  input  logic              trace_ready,
  output logic              trace_overflow
);
  typedef enum logic {RUN, HALTED} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic   running, halt_hit, push_vld, push_rdy;
  trace_t push_dat, head;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && halt_hit) state_d = HALTED;
  end

  always_comb begin
    running = (state_q == RUN);
    halted  = (state_q == HALTED);
  end

  always_comb begin
    halt_hit      = memwrite && (daddr == HALT_ADDR);
    push_vld      = running && memwrite && (daddr != HALT_ADDR);
    push_dat.addr = daddr;
    push_dat.data = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result         <= '0;
      cycle_cnt      <= '0;
      stall_cnt      <= '0;
      trace_overflow <= 1'b0;
    end else if (running) begin
      if (!(&cycle_cnt))         cycle_cnt <= cycle_cnt + CNT_ONE;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_ONE;
      if (halt_hit)              result    <= wdata;
      if (push_vld && !push_rdy) trace_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .W     (2 * DATA_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .push_rdy (push_rdy),
    .pop_vld  (trace_valid),
    .pop_dat  (head),
    .pop_rdy  (trace_ready)
  );

  always_comb begin
    trace_addr = head.addr;
    trace_data = head.data;
  end
endmodule

// File: tb/tb_perf_halt_mon.sv
// Scoreboarded bench: a posedge reference model queues expected trace entries; a negedge monitor checks.
module tb_perf_halt_mon;
  localparam logic [31:0] HALT = 32'h0000_7fff;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n, memwrite, stall, trace_ready;
  logic [31:0] daddr, wdata;
  logic        halted, trace_valid, trace_overflow;
  logic [31:0] result, cycle_cnt, stall_cnt, trace_addr, trace_data;

  perf_halt_mon dut (
    .clk(clk), .rst_n(rst_n), .memwrite(memwrite), .daddr(daddr), .wdata(wdata),
    .stall(stall), .halted(halted), .result(result), .cycle_cnt(cycle_cnt),
    .stall_cnt(stall_cnt), .trace_valid(trace_valid), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_ready(trace_ready), .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec-level state, trace FIFO as a bounded queue of {addr,data}.
  logic [63:0] sb_q[$];
  bit          started = 0;
  bit          m_halted, m_ovf;
  logic [31:0] m_result, m_cyc, m_stl;
  logic [63:0] m_last;

  always @(posedge clk) begin
    if (!rst_n) begin
      started  = 1;
      m_halted = 0; m_ovf = 0;
      m_result = 0; m_cyc = 0; m_stl = 0;
      m_last   = 0;
      sb_q.delete();
    end else if (started && !m_halted) begin
      if (m_cyc != 32'hffff_ffff) m_cyc = m_cyc + 1;
      if (stall && m_stl != 32'hffff_ffff) m_stl = m_stl + 1;
      if (memwrite && daddr == HALT) begin
        m_halted = 1;
        m_result = wdata;
      end else if (memwrite) begin
        // Any pop this edge was already removed by the monitor, so size<DEPTH is the room test.
        if (sb_q.size() < DEPTH) sb_q.push_back({daddr, wdata});
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("halted", halted, m_halted);
      chk("result", result, m_result);
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("stall_cnt", stall_cnt, m_stl);
      chk("overflow", trace_overflow, m_ovf);
      chk("trace_valid", trace_valid, sb_q.size() != 0);
      if (sb_q.size() != 0) begin
        chk("trace_head", {trace_addr, trace_data}, sb_q[0]);
        if (trace_ready) m_last = sb_q.pop_front();
      end else begin
        chk("idle_head", {trace_addr, trace_data}, m_last);
      end
    end
  end

  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                      input logic st, input logic rdy);
    memwrite = mw; daddr = a; wdata = d; stall = st; trace_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int stall_pos[3];
    int k;
    rst_n = 1'b0; memwrite = 0; daddr = 0; wdata = 0; stall = 0; trace_ready = 0;
    #1;
    do_reset();
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_trace_addr", trace_addr, 0);

    // 10 idle cycles, stall on 3 distinct random cycles
    stall_pos[0] = $urandom_range(0, 3);
    stall_pos[1] = $urandom_range(4, 6);
    stall_pos[2] = $urandom_range(7, 9);
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, (i == stall_pos[0] || i == stall_pos[1] || i == stall_pos[2]), 0);
    chk("idle_cycle_cnt", cycle_cnt, 10);
    chk("idle_stall_cnt", stall_cnt, 3);
    chk("idle_halted", halted, 0);

    // three stores held, then drained in order
    step(1, 32'h100, 32'hA, 0, 0);
    step(1, 32'h104, 32'hB, 1, 0);
    step(1, 32'h108, 32'hC, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("drain3_valid", trace_valid, 0);
    chk("drain3_ovf", trace_overflow, 0);

    // overflow: 9 stores into an 8-deep FIFO, then full drain
    for (int i = 0; i < 9; i++) step(1, 32'h200 + 4 * i, i + 1, 0, 0);
    chk("ovf_set", trace_overflow, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    chk("ovf_sticky", trace_overflow, 1);
    chk("ovf_drained", trace_valid, 0);

    // full + push + pop in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 32'h300 + 4 * i, 32'h50 + i, 0, 0);
    step(1, 32'h400, 32'h99, 0, 1);
    chk("fullpp_ovf", trace_overflow, 0);
    chk("fullpp_head", trace_data, 32'h51);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    chk("fullpp_drained", trace_valid, 0);

    // randomized traffic, occasional halts and resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 99);
      if (k < 2) do_reset();
      else step(($urandom_range(0, 1) == 1),
                (k < 5) ? HALT : (32'h1000 + 4 * $urandom_range(0, 15)),
                $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end

    // halt after 50 counted cycles with 4 entries pending
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'h500 + 4 * i, 32'h70 + i, $urandom_range(0, 1), 0);
    for (int i = 0; i < 46; i++) step(0, 0, 0, $urandom_range(0, 1), 0);
    step(1, HALT, 32'hDEAD_BEEF, 0, 0);
    chk("halt_flag", halted, 1);
    chk("halt_result", result, 32'hDEAD_BEEF);
    chk("halt_cycle_cnt", cycle_cnt, 51);
    step(1, HALT, 32'h1234, 0, 0);
    step(1, 32'h600, 32'h77, 1, 0);
    chk("halt_result_kept", result, 32'hDEAD_BEEF);
    chk("halt_cnt_frozen", cycle_cnt, 51);
    chk("halt_pending", trace_valid, 1);
    do_reset();
    chk("rst_halted", halted, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", trace_valid, 0);
    chk("rst_data", trace_data, 0);
    step(1, 32'h700, 32'h11, 0, 0);
    chk("post_rst_traced", trace_addr, 32'h700);

    // draining continues while halted
    step(1, 32'h704, 32'h12, 0, 0);
    step(1, HALT, 32'h5, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h800, 32'h1, 0, 1);
    chk("halted_drained", trace_valid, 0);
    chk("halted_result", result, 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
